// File: rtl/mac_array_skew.sv
// Weight-stationary ROW x COL systolic MAC array with ROW-deep instruction skew.
// Optional MAC_SAT_EN: saturate partial sums instead of wrapping.
module mac_array_skew #(
  parameter int unsigned BW      = 4,
  parameter int unsigned PSUM_BW = 16,
  parameter int unsigned ROW     = 8,
  parameter int unsigned COL     = 8,
  parameter int unsigned CNT_BW  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ROW*BW-1:0]      in_w,
  input  logic [PSUM_BW*COL-1:0] in_n,
  input  logic [2:0]             inst_w,
  output logic [PSUM_BW*COL-1:0] out_s,
  output logic [COL-1:0]         valid,
  output logic                   w_loaded,
  output logic [CNT_BW-1:0]      out_cnt
);

  localparam int unsigned PW = 2 * BW + 1;

  logic [2:0]         inst_sr_q [ROW];
  logic [BW-1:0]      a_out     [ROW][COL];
  logic [2:0]         inst_out  [ROW][COL];
  logic [PSUM_BW-1:0] c_out     [ROW][COL];
  logic               v_out     [ROW][COL];
  logic [ROW*COL-1:0] rdy_vec;
  logic               w_loaded_q;
  logic [CNT_BW-1:0]  out_cnt_q;

  // Row r picks its instruction from tap r, i.e. inst_w delayed r+1 cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ROW; i++) inst_sr_q[i] <= '0;
    end else begin
      inst_sr_q[0] <= inst_w;
      for (int i = 1; i < ROW; i++) inst_sr_q[i] <= inst_sr_q[i-1];
    end
  end

  for (genvar r = 0; r < ROW; r++) begin : g_row
    for (genvar c = 0; c < COL; c++) begin : g_col
      logic [BW-1:0]        a_in, a_q, b_q;
      logic [2:0]           inst_in, inst_q;
      logic [PSUM_BW-1:0]   n_in, c_q, c_d;
      logic                 valid_q, load_ready_q;
      logic signed [PW-1:0] a_ext, b_ext, prod;

      if (c == 0) begin : g_west
        assign a_in    = in_w[BW*r +: BW];
        assign inst_in = inst_sr_q[r];
      end else begin : g_east
        assign a_in    = a_out[r][c-1];
        assign inst_in = inst_out[r][c-1];
      end

      if (r == 0) begin : g_north
        assign n_in = in_n[PSUM_BW*c +: PSUM_BW];
      end else begin : g_south
        assign n_in = c_out[r-1][c];
      end

      always_comb begin
        a_ext = $signed(PW'(a_in));
        b_ext = PW'($signed(b_q));
        prod  = a_ext * b_ext;
`ifdef MAC_SAT_EN
        begin
          logic [PSUM_BW:0] sum;
          sum = {n_in[PSUM_BW-1], n_in} + (PSUM_BW+1)'(prod);
          // Top two bits disagree only when the signed sum left the PSUM_BW range.
          if (sum[PSUM_BW] != sum[PSUM_BW-1]) begin
            c_d = sum[PSUM_BW] ? {1'b1, {(PSUM_BW-1){1'b0}}} : {1'b0, {(PSUM_BW-1){1'b1}}};
          end else begin
            c_d = sum[PSUM_BW-1:0];
          end
        end
`else
        c_d = n_in + PSUM_BW'(prod);
`endif
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          a_q          <= '0;
          b_q          <= '0;
          c_q          <= '0;
          inst_q       <= '0;
          valid_q      <= 1'b0;
          load_ready_q <= 1'b1;
        end else begin
          inst_q  <= inst_in;
          valid_q <= 1'b0;
          if (inst_in[2]) begin
            b_q          <= '0;
            load_ready_q <= 1'b1;
            a_q          <= a_in;
          end else if (inst_in[0]) begin
            if (load_ready_q) begin
              // Capture the weight and consume the load so later words pass east.
              b_q          <= a_in;
              load_ready_q <= 1'b0;
              inst_q       <= 3'b000;
            end else begin
              a_q <= a_in;
            end
          end else if (inst_in[1]) begin
            a_q     <= a_in;
            c_q     <= c_d;
            valid_q <= 1'b1;
          end
        end
      end

      assign a_out[r][c]       = a_q;
      assign inst_out[r][c]    = inst_q;
      assign c_out[r][c]       = c_q;
      assign v_out[r][c]       = valid_q;
      assign rdy_vec[r*COL+c]  = load_ready_q;
    end
  end

  for (genvar c = 0; c < COL; c++) begin : g_out
    assign out_s[PSUM_BW*c +: PSUM_BW] = c_out[ROW-1][c];
    assign valid[c]                    = v_out[ROW-1][c];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_loaded_q <= 1'b0;
      out_cnt_q  <= '0;
    end else begin
      w_loaded_q <= &(~rdy_vec);
      if (inst_w[2]) begin
        out_cnt_q <= '0;
      end else if (valid[COL-1]) begin
        out_cnt_q <= out_cnt_q + CNT_BW'(1);
      end
    end
  end

  assign w_loaded = w_loaded_q;
  assign out_cnt  = out_cnt_q;

endmodule

// File: doc/mac_array_skew.md
Name: mac_array_skew

Overview:
- Parametrised weight-stationary systolic MAC array, ROW x COL processing elements (PEs).
- Successor to the fixed 8-row array: instruction skew depth follows ROW, and a weight-reload instruction is added.
- Adds array-wide weight-loaded status and an output-vector counter.
- Sits between the L0/activation feeder (west) and the OFIFO/psum path (south).

Parameters:
BW, 4, activation/weight width
PSUM_BW, 16, partial-sum width, signed two's complement
ROW, 8, PE rows (instruction skew depth)
COL, 8, PE columns
CNT_BW, 16, out_cnt width

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
in_w  input  ROW*BW  west data; row r in bits [BW*(r+1)-1:BW*r]; activations unsigned, weights signed
in_n  input  PSUM_BW*COL  north psum input, column c in slice c
inst_w  input  3  bit2 reload, bit1 execute, bit0 kernel load
out_s  output  PSUM_BW*COL  south psums from row ROW-1
valid  output  COL  per-column execute-valid from row ROW-1
w_loaded  output  1  every PE holds a weight
out_cnt  output  CNT_BW  completed output vectors since last reload/reset

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-low. While reset=0, every register clears immediately: inst pipeline 0, PE a_q/b_q/c_q 0, valid 0, load_ready 1, w_loaded 0, out_cnt 0.
- Instruction skew: a ROW-deep shift register driven by inst_w. Row r sees inst_w delayed r+1 cycles. Within a row, inst moves one column east per cycle.
- Timing: inst X held on inst_w in cycle k takes effect at PE(r,c) at the edge ending cycle k+1+r+c.
- Driver alignment: in_w row r is not registered; the driver presents it in cycle k+1+r. in_n column c is presented in cycle k+1+c.
- Instruction priority (multiple bits set): reload > load > execute.
- Reload (bit2): b_q<=0, load_ready<=1, a_q<=a_in; inst forwarded unchanged. Sampling reload on inst_w clears out_cnt the next edge.
- Load (bit0), load_ready=1: b_q<=a_in, load_ready<=0, a_q held; inst forwarded east as 000 (consumed).
- Load (bit0), load_ready=0: a_q<=a_in; inst forwarded unchanged.
- Load order: COL consecutive load cycles per row; word j lands in column j.
- Execute (bit1): a_q<=a_in, c_q<=in_n + a_in*b_q, valid_q<=1. Otherwise valid_q<=0 and c_q holds.
- Arithmetic: product is unsigned BW x signed BW, sign-extended to PSUM_BW. The sum wraps modulo 2^PSUM_BW.
- Output latency: out_s[c] and valid[c] for inst issued in cycle k appear in cycle k+1+ROW+c.
- PE load_ready=1 during execute: b_q=0, so it contributes in_n unchanged.
- w_loaded: registered AND over all ~load_ready. It rises 2 cycles after the last capture and falls the cycle after reload reaches any PE.
- out_cnt: +1 on each cycle valid[COL-1]=1, wraps at 2^CNT_BW. A reload clear on the same edge as an increment wins.
- Inst pipeline and PE state are never gated; no back-pressure. The downstream block must accept valid data every cycle.

Optional Feature:
MAC_SAT_EN
- Defined: c_q saturates to [-2^(PSUM_BW-1), 2^(PSUM_BW-1)-1] on overflow.
- Undefined: modulo wrap as above.
- No port change either way.

Test Plan:
- Reset: drive reset=0 mid-run -> out_s=0, valid=0, w_loaded=0, out_cnt=0 asynchronously; after release, first execute uses b_q=0.
- Weight load, ROW=COL=2: row0 words 3,-2; row1 words 1,5; load held cycles 0-1 -> b = {3,-2 ; 1,5}, w_loaded=1 from cycle 6.
- Execute, weights loaded: act row0=2, row1=4, in_n=0, inst at k=10 -> out_s col0=10 valid[0] in cycle 13; col1=16 valid[1] in cycle 14; out_cnt=1.
- Overflow: b=1, act=1, in_n col0=32767 -> -32768 without MAC_SAT_EN; 32767 with MAC_SAT_EN.
- Reload after 3 executes: out_cnt 3->0, w_loaded falls. Reload new weights 1,1;1,1 with act 2,4 -> col0=6, col1=6.
- Priority: inst_w=011 with all load_ready=1 -> weights captured, no valid; inst_w=111 -> treated as reload.
